clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Setting controller for the digital clock. It consumes the six debounced per-key press states (0 = idle, 1 = short-held, 2 = long-held) from the key-state block and runs the mode FSM: RUN, SET_TIME and SET_ALARM. It edits hour/min/sec shadow registers, commits them to the timekeeper or alarm registers with one-cycle load strobes, and drives a blink flag for the display.

Parameters:
REPEAT_MS, 200, auto-repeat period in 1 ms ticks while UP/DOWN is long-held
TIMEOUT_MS, 30000, idle ticks in a set mode before abandoning edits
BLINK_MS, 500, half-period of the blink flag in ticks

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tick_1ms  in  1  one-clk-wide strobe every 1 ms
key0_state..key5_state  in  4 each  press state per key; key0=MODE, key1=UP, key2=DOWN, key3=NEXT, key4=ALARM, key5=CONFIRM; values >2 treated as 0
cur_hour/cur_min/cur_sec  in  5/6/6  live time, binary
alm_hour/alm_min  in  5/6  stored alarm, binary
mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM
field  out  2  0=hour, 1=min, 2=sec
edit_hour/edit_min/edit_sec  out  5/6/6  shadow values being edited
time_load  out  1  one-cycle commit strobe for edit_* to the timekeeper
alarm_load  out  1  one-cycle commit strobe for edit_hour/edit_min to the alarm
alarm_en  out  1  alarm enable flag
blink  out  1  display blink for the selected field

Behaviour:
- Reset, asynchronous: mode=RUN, field=0, edit_*=0, time_load=alarm_load=0, alarm_en=0, blink=0, all counters 0, previous-state registers 0.
- Each key's state is registered every clk as prev. Events are derived combinationally, with no extra latency:
  - press: prev==0 and cur!=0.
  - long: prev!=2 and cur==2.
  - release_short: prev==1 and cur==0.
  - repeat (UP/DOWN only): cur==2, plus tick_1ms, plus the per-key repeat counter reaching REPEAT_MS-1. The counter clears when cur!=2.
- MODE uses release_short for its short action and long for its long action, so a long hold never fires the short action. UP, DOWN, NEXT, ALARM and CONFIRM act on press. UP and DOWN also act on long and repeat.
- Only one action is taken per clk. Priority is CONFIRM > MODE > NEXT > UP > DOWN > ALARM; lower-priority events in that cycle are dropped.
- RUN state:
  - MODE release_short -> SET_TIME, field=0, edit_* loaded from cur_*.
  - MODE long -> SET_ALARM, field=0, edit_hour/edit_min loaded from alm_*, edit_sec=0.
  - ALARM press -> alarm_en toggles.
  - Other keys are ignored.
- SET_TIME and SET_ALARM states:
  - NEXT press: field advances. SET_TIME cycles 0->1->2->0; SET_ALARM cycles 0->1->0.
  - UP: increments the selected field with wrap (hour 23->0, min/sec 59->0).
  - DOWN: decrements with wrap (0->23 or 0->59).
  - CONFIRM press: asserts time_load (SET_TIME) or alarm_load (SET_ALARM) for exactly one clk, registered. mode returns to RUN in the same edge. edit_* hold their values through that strobe.
  - MODE release_short or long: cancel, return to RUN, no strobe.
  - ALARM: ignored.
- Idle timeout:
  - A counter increments on tick_1ms while in a set mode and clears on any accepted action.
  - When it reaches TIMEOUT_MS-1 on a tick, mode returns to RUN with no strobe.
  - It clears on entry to RUN.
- Blink:
  - Toggles every BLINK_MS ticks in set modes.
  - Forced to 1 and its counter reset on any accepted UP/DOWN action, so the edited value stays visible.
  - 0 in RUN.
- edit_* are never written outside set modes except on entry loads. Out-of-range cur_* values (e.g. hour 24..31) are loaded unchanged. The first UP then wraps them to 0 (hour >=23 -> 0, min/sec >=59 -> 0).
- Reset asserted mid-edit aborts immediately with no load strobe.
- Counter widths: 16 bits for the repeat and blink counters, 16 bits for the timeout counter (parameters up to 65535).

Test Plan:
- RUN, cur=12:34:56, MODE goes 0->1->0 -> mode=1, field=0, edit=12:34:56. Then UP press x12 -> edit_hour=0. Then CONFIRM press -> time_load high exactly 1 clk with edit=00:34:56, mode=0.
- RUN, MODE goes 0->1->2, held then released -> mode=2, edit_hour/min=alm_*, no SET_TIME entry. Then NEXT x2 -> field 1 then 0. Then CONFIRM -> alarm_load pulse, time_load stays 0.
- SET_TIME, field=1, edit_min=0, DOWN press -> 59. Then UP held at state 2 for 1000 ticks -> 1 long step + 5 repeats, edit_min=5.
- SET_TIME, no keys for 30000 ticks -> mode=0 on the 30000th tick, no strobe. Also check that a key at tick 29999 restarts the count.
- Same clk: CONFIRM press + UP press -> only the load happens, edit unchanged. In RUN, ALARM press x2 -> alarm_en 1 then 0.
- Assert reset_n low mid-SET_TIME with UP held -> all outputs at reset values, no time_load.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Mode and edit controller for the digital clock: key events, shadow
// time/alarm edits, commit strobes, idle timeout and field blink.
module clock_set_ctrl #(
    parameter int REPEAT_MS  = 200,
    parameter int TIMEOUT_MS = 30000,
    parameter int BLINK_MS   = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1ms,
    input  logic [3:0] key0_state,
    input  logic [3:0] key1_state,
    input  logic [3:0] key2_state,
    input  logic [3:0] key3_state,
    input  logic [3:0] key4_state,
    input  logic [3:0] key5_state,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alm_hour,
    input  logic [5:0] alm_min,
    output logic [1:0] mode,
    output logic [1:0] field,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min,
    output logic [5:0] edit_sec,
    output logic       time_load,
    output logic       alarm_load,
    output logic       alarm_en,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } state_t;

    localparam logic [15:0] REP_LAST = 16'(REPEAT_MS - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_MS - 1);
    localparam logic [15:0] BL_LAST  = 16'(BLINK_MS - 1);

    state_t      state, state_nx;
    logic [1:0]  cur  [6];
    logic [1:0]  prev [6];
    logic [15:0] up_cnt, dn_cnt, to_cnt, bl_cnt;
    logic        in_set, to_fire, up_rpt, dn_rpt;
    logic        mode_short, mode_long;
    logic        up_ev, dn_ev, next_press, alarm_press, confirm_press;
    logic        ev_confirm, ev_mode, ev_next, ev_up, ev_down, ev_alarm;
    logic        do_confirm, do_mode, do_next, do_up, do_down, do_alarm;
    logic        accepted;

    function automatic logic [1:0] norm(input logic [3:0] s);
        return (s > 4'd2) ? 2'd0 : s[1:0];
    endfunction

    function automatic logic pressed(input logic [1:0] p,
                                     input logic [1:0] c);
        return (p == 2'd0) && (c != 2'd0);
    endfunction

    function automatic logic longed(input logic [1:0] p,
                                    input logic [1:0] c);
        return (p != 2'd2) && (c == 2'd2);
    endfunction

    function automatic logic [4:0] step_hour(input logic [4:0] v,
                                             input logic       inc);
        if (inc) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] step_60(input logic [5:0] v,
                                           input logic       inc);
        if (inc) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    always_comb begin
        cur[0] = norm(key0_state);
        cur[1] = norm(key1_state);
        cur[2] = norm(key2_state);
        cur[3] = norm(key3_state);
        cur[4] = norm(key4_state);
        cur[5] = norm(key5_state);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 6; i++) prev[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 6; i++) prev[i] <= cur[i];
        end
    end

    // Auto-repeat counters run whenever the key sits in the long state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_cnt <= '0;
            dn_cnt <= '0;
        end else begin
            if (cur[1] != 2'd2) up_cnt <= '0;
            else if (tick_1ms)
                up_cnt <= (up_cnt == REP_LAST) ? '0 : up_cnt + 16'd1;
            if (cur[2] != 2'd2) dn_cnt <= '0;
            else if (tick_1ms)
                dn_cnt <= (dn_cnt == REP_LAST) ? '0 : dn_cnt + 16'd1;
        end
    end

    assign up_rpt = (cur[1] == 2'd2) && tick_1ms && (up_cnt == REP_LAST);
    assign dn_rpt = (cur[2] == 2'd2) && tick_1ms && (dn_cnt == REP_LAST);

    assign mode_short    = (prev[0] == 2'd1) && (cur[0] == 2'd0);
    assign mode_long     = longed(prev[0], cur[0]);
    assign up_ev         = pressed(prev[1], cur[1])
                         | longed(prev[1], cur[1]) | up_rpt;
    assign dn_ev         = pressed(prev[2], cur[2])
                         | longed(prev[2], cur[2]) | dn_rpt;
    assign next_press    = pressed(prev[3], cur[3]);
    assign alarm_press   = pressed(prev[4], cur[4]);
    assign confirm_press = pressed(prev[5], cur[5]);

    assign in_set     = (state != RUN);
    assign ev_confirm = in_set && confirm_press;
    assign ev_mode    = mode_short || mode_long;
    assign ev_next    = in_set && next_press;
    assign ev_up      = in_set && up_ev;
    assign ev_down    = in_set && dn_ev;
    assign ev_alarm   = !in_set && alarm_press;

    // Fixed priority: at most one action wins each clock.
    assign do_confirm = ev_confirm;
    assign do_mode    = ev_mode && !ev_confirm;
    assign do_next    = ev_next && !(ev_confirm || ev_mode);
    assign do_up      = ev_up && !(ev_confirm || ev_mode || ev_next);
    assign do_down    = ev_down
                      && !(ev_confirm || ev_mode || ev_next || ev_up);
    assign do_alarm   = ev_alarm
                      && !(ev_confirm || ev_mode || ev_next
                           || ev_up || ev_down);
    assign accepted   = do_confirm || do_mode || do_next
                      || do_up || do_down || do_alarm;

    assign to_fire = in_set && tick_1ms && (to_cnt == TO_LAST)
                   && !accepted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (do_mode)
                    state_nx = mode_short ? SET_TIME : SET_ALARM;
            end
            default: begin
                if (do_confirm || do_mode || to_fire) state_nx = RUN;
            end
        endcase
    end

    always_comb begin
        mode = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            field      <= 2'd0;
            edit_hour  <= '0;
            edit_min   <= '0;
            edit_sec   <= '0;
            time_load  <= 1'b0;
            alarm_load <= 1'b0;
            alarm_en   <= 1'b0;
        end else begin
            time_load  <= do_confirm && (state == SET_TIME);
            alarm_load <= do_confirm && (state == SET_ALARM);
            if (do_alarm) alarm_en <= ~alarm_en;
            if (!in_set && state_nx == SET_TIME) begin
                field     <= 2'd0;
                edit_hour <= cur_hour;
                edit_min  <= cur_min;
                edit_sec  <= cur_sec;
            end else if (!in_set && state_nx == SET_ALARM) begin
                field     <= 2'd0;
                edit_hour <= alm_hour;
                edit_min  <= alm_min;
                edit_sec  <= '0;
            end else if (in_set && state_nx == RUN) begin
                field <= 2'd0;
            end else if (do_next) begin
                if (state == SET_TIME)
                    field <= (field == 2'd2) ? 2'd0 : field + 2'd1;
                else
                    field <= (field == 2'd0) ? 2'd1 : 2'd0;
            end else if (do_up || do_down) begin
                case (field)
                    2'd0:    edit_hour <= step_hour(edit_hour, do_up);
                    2'd1:    edit_min  <= step_60(edit_min, do_up);
                    default: edit_sec  <= step_60(edit_sec, do_up);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (!in_set || state_nx == RUN || accepted) begin
            to_cnt <= '0;
        end else if (tick_1ms) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // UP/DOWN restart the blink phase with the field shown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink  <= 1'b0;
            bl_cnt <= '0;
        end else if (state_nx == RUN) begin
            blink  <= 1'b0;
            bl_cnt <= '0;
        end else if (do_up || do_down) begin
            blink  <= 1'b1;
            bl_cnt <= '0;
        end else if (in_set && tick_1ms) begin
            if (bl_cnt == BL_LAST) begin
                blink  <= ~blink;
                bl_cnt <= '0;
            end else begin
                bl_cnt <= bl_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized and directed bench for clock_set_ctrl against a
// behavioural model of the key/mode rules.
module tb_clock_set_ctrl;

    localparam int REPEAT_MS  = 200;
    localparam int TIMEOUT_MS = 30000;
    localparam int BLINK_MS   = 500;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick_1ms;
    logic [3:0] keys [6];
    logic [4:0] cur_hour, alm_hour;
    logic [5:0] cur_min, cur_sec, alm_min;
    logic [1:0] mode, field;
    logic [4:0] edit_hour;
    logic [5:0] edit_min, edit_sec;
    logic       time_load, alarm_load, alarm_en, blink;
    logic [24:0] dvec;

    int total = 0;
    int bad   = 0;

    int m_mode, m_field, m_h, m_mi, m_s, m_idle, m_bt;
    bit m_tl, m_al, m_aen, m_blink;
    int m_prev [6];
    int m_held [2];

    clock_set_ctrl #(
        .REPEAT_MS (REPEAT_MS),
        .TIMEOUT_MS(TIMEOUT_MS),
        .BLINK_MS  (BLINK_MS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick_1ms  (tick_1ms),
        .key0_state(keys[0]),
        .key1_state(keys[1]),
        .key2_state(keys[2]),
        .key3_state(keys[3]),
        .key4_state(keys[4]),
        .key5_state(keys[5]),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .alm_hour  (alm_hour),
        .alm_min   (alm_min),
        .mode      (mode),
        .field     (field),
        .edit_hour (edit_hour),
        .edit_min  (edit_min),
        .edit_sec  (edit_sec),
        .time_load (time_load),
        .alarm_load(alarm_load),
        .alarm_en  (alarm_en),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    assign dvec = {mode, field, edit_hour, edit_min, edit_sec,
                   time_load, alarm_load, alarm_en, blink};

    function automatic logic [24:0] mvec();
        return {2'(m_mode), 2'(m_field), 5'(m_h), 6'(m_mi), 6'(m_s),
                m_tl, m_al, m_aen, m_blink};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_h = 0; m_mi = 0; m_s = 0;
        m_idle = 0; m_bt = 0;
        m_tl = 0; m_al = 0; m_aen = 0; m_blink = 0;
        for (int i = 0; i < 6; i++) m_prev[i] = 0;
        m_held[0] = 0; m_held[1] = 0;
    endtask

    // One clock of the reference: events, priority pick, effect.
    task automatic model_clock();
        int n [6];
        bit rep [2];
        bit pr [6];
        bit lg [6];
        bit set;
        int act;
        for (int i = 0; i < 6; i++) begin
            n[i]  = (keys[i] > 2) ? 0 : int'(keys[i]);
            pr[i] = (m_prev[i] == 0) && (n[i] != 0);
            lg[i] = (m_prev[i] != 2) && (n[i] == 2);
        end
        for (int i = 0; i < 2; i++) begin
            if (n[i+1] == 2) begin
                if (tick_1ms) m_held[i]++;
            end else begin
                m_held[i] = 0;
            end
            rep[i] = (n[i+1] == 2) && tick_1ms
                   && (m_held[i] % REPEAT_MS == 0);
        end
        set = (m_mode != 0);
        act = 0;
        if (set && pr[5]) act = 1;
        else if ((m_prev[0] == 1 && n[0] == 0) || lg[0]) act = 2;
        else if (set && pr[3]) act = 3;
        else if (set && (pr[1] || lg[1] || rep[0])) act = 4;
        else if (set && (pr[2] || lg[2] || rep[1])) act = 5;
        else if (!set && pr[4]) act = 6;
        m_tl = 0;
        m_al = 0;
        case (act)
            1, 2: begin
                if (act == 2 && !set) begin
                    m_field = 0;
                    if (n[0] == 0) begin
                        m_mode = 1;
                        m_h = int'(cur_hour); m_mi = int'(cur_min);
                        m_s = int'(cur_sec);
                    end else begin
                        m_mode = 2;
                        m_h = int'(alm_hour); m_mi = int'(alm_min);
                        m_s = 0;
                    end
                end else begin
                    m_tl = (act == 1) && (m_mode == 1);
                    m_al = (act == 1) && (m_mode == 2);
                    m_mode = 0; m_field = 0; m_idle = 0;
                    m_blink = 0; m_bt = 0;
                end
            end
            3: begin
                m_field = (m_field + 1) % ((m_mode == 1) ? 3 : 2);
                m_idle = 0;
            end
            4, 5: begin
                if (m_field == 0)
                    m_h = (act == 4) ? ((m_h >= 23) ? 0 : m_h + 1)
                                     : ((m_h == 0) ? 23 : m_h - 1);
                else if (m_field == 1)
                    m_mi = (act == 4) ? ((m_mi >= 59) ? 0 : m_mi + 1)
                                      : ((m_mi == 0) ? 59 : m_mi - 1);
                else
                    m_s = (act == 4) ? ((m_s >= 59) ? 0 : m_s + 1)
                                     : ((m_s == 0) ? 59 : m_s - 1);
                m_idle = 0; m_blink = 1; m_bt = 0;
            end
            6: m_aen = !m_aen;
            default: begin
                if (set && tick_1ms) begin
                    m_idle++;
                    if (m_idle == TIMEOUT_MS) begin
                        m_mode = 0; m_field = 0; m_idle = 0;
                        m_blink = 0; m_bt = 0;
                    end
                end
            end
        endcase
        if (m_mode != 0 && set && tick_1ms && (act == 0 || act == 3)) begin
            m_bt++;
            if (m_bt == BLINK_MS) begin
                m_blink = !m_blink;
                m_bt = 0;
            end
        end
        for (int i = 0; i < 6; i++) m_prev[i] = n[i];
    endtask

    task automatic step(input bit t);
        tick_1ms = t;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_keys();
        for (int i = 0; i < 6; i++) keys[i] = 4'd0;
    endtask

    task automatic enter_set_time();
        keys[0] = 4'd1; step(0);
        keys[0] = 4'd0; step(0);
    endtask

    task automatic test_reset();
        clear_keys();
        tick_1ms = 0;
        cur_hour = 0; cur_min = 0; cur_sec = 0;
        alm_hour = 0; alm_min = 0;
        reset_n = 0;
        model_reset();
        #2;
        total++;
        if (dvec !== 25'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", dvec, 25'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        step(0);
        total++;
        if (dvec !== mvec()) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", dvec, mvec());
        end
    endtask

    task automatic test_set_time();
        cur_hour = 12; cur_min = 34; cur_sec = 56;
        enter_set_time();
        cur_hour = 3; cur_min = 4; cur_sec = 5;
        total++;
        if ({mode, field, edit_hour, edit_min, edit_sec} !==
            {2'd1, 2'd0, 5'd12, 6'd34, 6'd56}) begin
            bad++;
            $display("FAIL enter_time got=%h/%0d %0d:%0d:%0d want=1/0 12:34:56",
                     mode, field, edit_hour, edit_min, edit_sec);
        end
        for (int i = 0; i < 12; i++) begin
            keys[1] = 4'd1; step(0);
            keys[1] = 4'd0; step(0);
        end
        total++;
        if (edit_hour !== 5'd0 || dvec !== mvec()) begin
            bad++;
            $display("FAIL hour_wrap got=%0d want=0", edit_hour);
        end
        keys[5] = 4'd1; step(0);
        total++;
        if ({time_load, alarm_load, mode, edit_hour, edit_min, edit_sec}
            !== {1'b1, 1'b0, 2'd0, 5'd0, 6'd34, 6'd56}) begin
            bad++;
            $display("FAIL time_commit got=%b%b m%0d %0d:%0d:%0d want=10 m0 0:34:56",
                     time_load, alarm_load, mode, edit_hour, edit_min,
                     edit_sec);
        end
        keys[5] = 4'd0; step(0);
        total++;
        if (time_load !== 1'b0 || dvec !== mvec()) begin
            bad++;
            $display("FAIL time_pulse_len got=%b want=0", time_load);
        end
    endtask

    task automatic test_set_alarm();
        alm_hour = 7; alm_min = 45;
        keys[0] = 4'd1; step(0);
        keys[0] = 4'd2; step(0);
        total++;
        if ({mode, field, edit_hour, edit_min, edit_sec} !==
            {2'd2, 2'd0, 5'd7, 6'd45, 6'd0}) begin
            bad++;
            $display("FAIL enter_alarm got=%0d %0d:%0d:%0d want=2 7:45:0",
                     mode, edit_hour, edit_min, edit_sec);
        end
        repeat (3) step(0);
        keys[0] = 4'd0; step(0);
        total++;
        if (mode !== 2'd2 || dvec !== mvec()) begin
            bad++;
            $display("FAIL long_release got=%0d want=2", mode);
        end
        keys[3] = 4'd1; step(0);
        total++;
        if (field !== 2'd1) begin
            bad++;
            $display("FAIL alarm_next1 got=%0d want=1", field);
        end
        keys[3] = 4'd0; step(0);
        keys[3] = 4'd1; step(0);
        total++;
        if (field !== 2'd0) begin
            bad++;
            $display("FAIL alarm_next2 got=%0d want=0", field);
        end
        keys[3] = 4'd0; step(0);
        keys[5] = 4'd1; step(0);
        total++;
        if ({alarm_load, time_load, mode} !== {1'b1, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL alarm_commit got=%b%b m%0d want=10 m0",
                     alarm_load, time_load, mode);
        end
        keys[5] = 4'd0; step(0);
    endtask

    task automatic test_updown_repeat();
        cur_hour = 10; cur_min = 0; cur_sec = 30;
        enter_set_time();
        keys[3] = 4'd1; step(0);
        keys[3] = 4'd0; step(0);
        keys[2] = 4'd1; step(0);
        total++;
        if (edit_min !== 6'd59 || field !== 2'd1) begin
            bad++;
            $display("FAIL min_down_wrap got=%0d want=59", edit_min);
        end
        keys[2] = 4'd0; step(0);
        keys[1] = 4'd2; step(0);
        repeat (1000) step(1);
        total++;
        if ({edit_min, blink, mode} !== {6'd5, 1'b1, 2'd1}
            || dvec !== mvec()) begin
            bad++;
            $display("FAIL up_repeat got=%0d b%b want=5 b1", edit_min, blink);
        end
        keys[1] = 4'd0; step(0);
        keys[0] = 4'd1; step(0);
        keys[0] = 4'd0; step(0);
        total++;
        if ({mode, time_load} !== {2'd0, 1'b0} || dvec !== mvec()) begin
            bad++;
            $display("FAIL cancel got=%h want=%h", dvec, mvec());
        end
    endtask

    task automatic test_timeout();
        cur_hour = 1; cur_min = 2; cur_sec = 3;
        enter_set_time();
        repeat (TIMEOUT_MS - 1) step(1);
        total++;
        if (mode !== 2'd1 || dvec !== mvec()) begin
            bad++;
            $display("FAIL timeout_early got=%0d want=1", mode);
        end
        step(1);
        total++;
        if ({mode, time_load, alarm_load} !== {2'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL timeout_exit got=%0d %b%b want=0 00",
                     mode, time_load, alarm_load);
        end
        enter_set_time();
        repeat (TIMEOUT_MS - 2) step(1);
        keys[3] = 4'd1; step(1);
        keys[3] = 4'd0; step(1);
        step(1);
        total++;
        if (mode !== 2'd1 || dvec !== mvec()) begin
            bad++;
            $display("FAIL timeout_restart got=%0d want=1", mode);
        end
        keys[0] = 4'd1; step(0);
        keys[0] = 4'd0; step(0);
    endtask

    task automatic test_same_clk();
        cur_hour = 5; cur_min = 6; cur_sec = 7;
        enter_set_time();
        keys[5] = 4'd1; keys[1] = 4'd1; step(0);
        total++;
        if ({time_load, mode, edit_hour} !== {1'b1, 2'd0, 5'd5}) begin
            bad++;
            $display("FAIL confirm_wins got=%b m%0d h%0d want=1 m0 h5",
                     time_load, mode, edit_hour);
        end
        clear_keys(); step(0);
        keys[4] = 4'd1; step(0);
        total++;
        if (alarm_en !== 1'b1) begin
            bad++;
            $display("FAIL alarm_on got=%b want=1", alarm_en);
        end
        keys[4] = 4'd0; step(0);
        keys[4] = 4'd1; step(0);
        total++;
        if (alarm_en !== 1'b0 || dvec !== mvec()) begin
            bad++;
            $display("FAIL alarm_off got=%b want=0", alarm_en);
        end
        keys[4] = 4'd0; step(0);
    endtask

    task automatic test_reset_mid();
        cur_hour = 20; cur_min = 30; cur_sec = 40;
        enter_set_time();
        keys[1] = 4'd2;
        repeat (50) step(1);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        total++;
        if (dvec !== 25'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=%h", dvec, 25'd0);
        end
        @(posedge clk); #1;
        total++;
        if (dvec !== 25'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", dvec, 25'd0);
        end
        reset_n = 1;
        keys[1] = 4'd0;
        step(0);
        total++;
        if (dvec !== mvec()) begin
            bad++;
            $display("FAIL reset_exit got=%h want=%h", dvec, mvec());
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < 6; i++) begin
                r = int'($urandom_range(0, 63));
                if (r < 6) keys[i] = 4'($urandom_range(0, 2));
                else if (r == 6) keys[i] = 4'($urandom_range(0, 15));
            end
            cur_hour = 5'($urandom_range(0, 31));
            cur_min  = 6'($urandom_range(0, 63));
            cur_sec  = 6'($urandom_range(0, 63));
            alm_hour = 5'($urandom_range(0, 31));
            alm_min  = 6'($urandom_range(0, 63));
            step($urandom_range(0, 3) == 0);
            total++;
            if (dvec !== mvec()) begin
                bad++;
                $display("FAIL random c=%0d got=%h want=%h", c, dvec, mvec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_time();
        test_set_alarm();
        test_updown_repeat();
        test_timeout();
        test_same_clk();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
